cv32e40p_ex_wb_pipeline: RTL and testbench

Receiving end of the EX stage output. The block captures results retired by EX into a registered EX/WB pipeline stage with a 2-entry skid buffer. It presents them to the write-back port with a valid/ready handshake and returns a registered `ex_ready_o` back-pressure to EX, so WB stalls never create a combinational path into ID/EX. It sits between the EX stage (ALU/MUL/LSU result mux) and the register-file write port.

---
 rtl/cv32e40p_pkg.sv | 21 ++
 rtl/cv32e40p_ex_wb_parity.sv | 13 +
 rtl/cv32e40p_ex_wb_pipeline.sv | 150 +++++++++++++++
 tb/tb_cv32e40p_ex_wb_pipeline.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_pkg.sv
// Shared types for the EX/WB pipeline stage: the stored entry and the buffer state.
package cv32e40p_pkg;

    localparam int unsigned EX_WB_ADDR_W = 6;
    localparam int unsigned EX_WB_PC_W   = 32;

    typedef struct packed {
        logic                    we;
        logic [EX_WB_ADDR_W-1:0] waddr;
        logic [31:0]             wdata;
        logic                    load_event;
        logic [EX_WB_PC_W-1:0]   pc;
    } ex_wb_entry_t;

    typedef enum logic [1:0] {
        EX_WB_EMPTY = 2'd0,
        EX_WB_ONE   = 2'd1,
        EX_WB_FULL  = 2'd2
    } ex_wb_state_e;

endpackage

// File: rtl/cv32e40p_ex_wb_parity.sv
// Even parity over the register-file write fields of an entry; combinational.
module cv32e40p_ex_wb_parity #(
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [31:0]           wdata_i,
    output logic                  parity_o
);

    assign parity_o = ^{we_i, waddr_i, wdata_i};

endmodule

// File: rtl/cv32e40p_ex_wb_pipeline.sv
// EX/WB pipeline stage: head register plus one skid entry, registered ex_ready_o.
// Optional parity protection of stored entries under `EX_WB_PARITY_EN.
module cv32e40p_ex_wb_pipeline
    import cv32e40p_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = EX_WB_ADDR_W,
    parameter int unsigned PC_WIDTH   = EX_WB_PC_W
) (
    input  logic                  clk_g,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  ex_valid_i,
    output logic                  ex_ready_o,
    input  logic                  regfile_we_ex_i,
    input  logic [ADDR_WIDTH-1:0] regfile_waddr_ex_i,
    input  logic [31:0]           regfile_wdata_ex_i,
    input  logic                  data_load_event_ex_i,
    input  logic                  data_misaligned_ex_i,
    input  logic [PC_WIDTH-1:0]   pc_ex_i,
    output logic                  wb_valid_o,
    input  logic                  wb_ready_i,
    output logic                  regfile_we_wb_o,
    output logic [ADDR_WIDTH-1:0] regfile_waddr_wb_o,
    output logic [31:0]           regfile_wdata_wb_o,
    output logic                  data_load_event_wb_o,
    output logic [PC_WIDTH-1:0]   pc_wb_o,
    output logic                  parity_err_o
);

    ex_wb_state_e state_q, state_d;
    ex_wb_entry_t head_q, skid_q, entry_in;
    logic         ex_ready_q, ex_ready_d;
    logic         accept, consume, load_head, load_skid, head_from_skid;

    // First half of a misaligned access must never write or signal an event.
    always_comb begin
        entry_in.we         = regfile_we_ex_i & ~data_misaligned_ex_i;
        entry_in.waddr      = regfile_waddr_ex_i;
        entry_in.wdata      = regfile_wdata_ex_i;
        entry_in.load_event = data_load_event_ex_i & ~data_misaligned_ex_i;
        entry_in.pc         = pc_ex_i;
    end

    assign wb_valid_o = (state_q != EX_WB_EMPTY);
    assign accept     = ex_valid_i & ex_ready_q;
    assign consume    = wb_valid_o & wb_ready_i;

    always_comb begin
        state_d        = state_q;
        load_head      = 1'b0;
        load_skid      = 1'b0;
        head_from_skid = 1'b0;
        if (flush_i) begin
            state_d = EX_WB_EMPTY;
        end else begin
            unique case (state_q)
                EX_WB_EMPTY: begin
                    if (accept) begin
                        load_head = 1'b1;
                        state_d   = EX_WB_ONE;
                    end
                end
                EX_WB_ONE: begin
                    if (accept && consume) begin
                        load_head = 1'b1;
                    end else if (accept) begin
                        load_skid = 1'b1;
                        state_d   = EX_WB_FULL;
                    end else if (consume) begin
                        state_d = EX_WB_EMPTY;
                    end
                end
                EX_WB_FULL: begin
                    if (consume) begin
                        head_from_skid = 1'b1;
                        state_d        = EX_WB_ONE;
                    end
                end
                default: state_d = EX_WB_EMPTY;
            endcase
        end
        ex_ready_d = (state_d != EX_WB_FULL) | flush_i;
    end

`ifdef EX_WB_PARITY_EN
    logic in_par, head_par_calc, head_par_q, skid_par_q, parity_err_q;

    cv32e40p_ex_wb_parity #(.ADDR_WIDTH(ADDR_WIDTH)) u_par_in (
        .we_i     (entry_in.we),
        .waddr_i  (entry_in.waddr),
        .wdata_i  (entry_in.wdata),
        .parity_o (in_par)
    );

    cv32e40p_ex_wb_parity #(.ADDR_WIDTH(ADDR_WIDTH)) u_par_head (
        .we_i     (head_q.we),
        .waddr_i  (head_q.waddr),
        .wdata_i  (head_q.wdata),
        .parity_o (head_par_calc)
    );

    assign parity_err_o = parity_err_q;
`else
    assign parity_err_o = 1'b0;
`endif

    always_ff @(posedge clk_g or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EX_WB_EMPTY;
            ex_ready_q <= 1'b1;
            head_q     <= '0;
            skid_q     <= '0;
`ifdef EX_WB_PARITY_EN
            head_par_q   <= 1'b0;
            skid_par_q   <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ex_ready_q <= ex_ready_d;
            if (load_head) begin
                head_q <= entry_in;
            end else if (head_from_skid) begin
                head_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= entry_in;
            end
`ifdef EX_WB_PARITY_EN
            if (load_head) begin
                head_par_q <= in_par;
            end else if (head_from_skid) begin
                head_par_q <= skid_par_q;
            end
            if (load_skid) begin
                skid_par_q <= in_par;
            end
            parity_err_q <= wb_valid_o & (head_par_calc != head_par_q);
`endif
        end
    end

    assign ex_ready_o           = ex_ready_q;
    assign regfile_we_wb_o      = wb_valid_o & head_q.we;
    assign regfile_waddr_wb_o   = head_q.waddr;
    assign regfile_wdata_wb_o   = head_q.wdata;
    assign data_load_event_wb_o = wb_valid_o & head_q.load_event;
    assign pc_wb_o              = head_q.pc;

endmodule

// File: tb/tb_cv32e40p_ex_wb_pipeline.sv
// Scoreboard bench for the EX/WB stage: stimulus pushes expected entries, a monitor pops on consume.
module tb_cv32e40p_ex_wb_pipeline;

    typedef struct {
        logic        we;
        logic [5:0]  waddr;
        logic [31:0] wdata;
        logic        le;
        logic [31:0] pc;
    } exp_t;

    logic        clk_g = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic        ex_valid_i = 1'b0;
    logic        ex_ready_o;
    logic        regfile_we_ex_i = 1'b0;
    logic [5:0]  regfile_waddr_ex_i = '0;
    logic [31:0] regfile_wdata_ex_i = '0;
    logic        data_load_event_ex_i = 1'b0;
    logic        data_misaligned_ex_i = 1'b0;
    logic [31:0] pc_ex_i = '0;
    logic        wb_valid_o;
    logic        wb_ready_i = 1'b0;
    logic        regfile_we_wb_o;
    logic [5:0]  regfile_waddr_wb_o;
    logic [31:0] regfile_wdata_wb_o;
    logic        data_load_event_wb_o;
    logic [31:0] pc_wb_o;
    logic        parity_err_o;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    cv32e40p_ex_wb_pipeline #(.ADDR_WIDTH(6), .PC_WIDTH(32)) dut (
        .clk_g                (clk_g),
        .rst_n                (rst_n),
        .flush_i              (flush_i),
        .ex_valid_i           (ex_valid_i),
        .ex_ready_o           (ex_ready_o),
        .regfile_we_ex_i      (regfile_we_ex_i),
        .regfile_waddr_ex_i   (regfile_waddr_ex_i),
        .regfile_wdata_ex_i   (regfile_wdata_ex_i),
        .data_load_event_ex_i (data_load_event_ex_i),
        .data_misaligned_ex_i (data_misaligned_ex_i),
        .pc_ex_i              (pc_ex_i),
        .wb_valid_o           (wb_valid_o),
        .wb_ready_i           (wb_ready_i),
        .regfile_we_wb_o      (regfile_we_wb_o),
        .regfile_waddr_wb_o   (regfile_waddr_wb_o),
        .regfile_wdata_wb_o   (regfile_wdata_wb_o),
        .data_load_event_wb_o (data_load_event_wb_o),
        .pc_wb_o              (pc_wb_o),
        .parity_err_o         (parity_err_o)
    );

    always #5 clk_g = ~clk_g;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_g);
        #1;
    endtask

    // Drive one EX entry; push it to the scoreboard only when it is expected to retire.
    task automatic drive(input logic we, input logic [5:0] addr, input logic [31:0] data,
                         input logic le, input logic mis, input logic [31:0] pc,
                         input bit expect_out);
        exp_t e;
        ex_valid_i           = 1'b1;
        regfile_we_ex_i      = we;
        regfile_waddr_ex_i   = addr;
        regfile_wdata_ex_i   = data;
        data_load_event_ex_i = le;
        data_misaligned_ex_i = mis;
        pc_ex_i              = pc;
        if (expect_out) begin
            e.we    = we & ~mis;
            e.waddr = addr;
            e.wdata = data;
            e.le    = le & ~mis;
            e.pc    = pc;
            sb.push_back(e);
        end
    endtask

    task automatic idle_in();
        ex_valid_i           = 1'b0;
        data_misaligned_ex_i = 1'b0;
    endtask

    always @(negedge clk_g) begin
        if (rst_n && wb_valid_o && wb_ready_i) begin
            if (sb.size() == 0) begin
                check("unexpected_output_waddr", {26'd0, regfile_waddr_wb_o}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("wb_waddr", {26'd0, regfile_waddr_wb_o}, {26'd0, e.waddr});
                check("wb_wdata", regfile_wdata_wb_o, e.wdata);
                check("wb_we", {31'd0, regfile_we_wb_o}, {31'd0, e.we});
                check("wb_load_event", {31'd0, data_load_event_wb_o}, {31'd0, e.le});
                check("wb_pc", pc_wb_o, e.pc);
            end
        end
`ifndef EX_WB_PARITY_EN
        if (parity_err_o !== 1'b0) check("parity_err_tied_low", {31'd0, parity_err_o}, 32'd0);
`endif
    end

    task automatic check_idle(input string tag);
        check({tag, "_ex_ready"}, {31'd0, ex_ready_o}, 32'd1);
        check({tag, "_wb_valid"}, {31'd0, wb_valid_o}, 32'd0);
        check({tag, "_we_wb"}, {31'd0, regfile_we_wb_o}, 32'd0);
        check({tag, "_le_wb"}, {31'd0, data_load_event_wb_o}, 32'd0);
    endtask

    initial begin
        // Reset and idle
        tick();
        check_idle("reset");
        check("reset_waddr", {26'd0, regfile_waddr_wb_o}, 32'd0);
        check("reset_wdata", regfile_wdata_wb_o, 32'd0);
        check("reset_pc", pc_wb_o, 32'd0);
        check("reset_parity", {31'd0, parity_err_o}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check_idle("idle");

        // Streaming with wb_ready high
        wb_ready_i = 1'b1;
        drive(1'b1, 6'd5, 32'hA5A5_A5A5, 1'b0, 1'b0, 32'h0000_0100, 1'b1);
        tick();
        check("stream_latency_valid", {31'd0, wb_valid_o}, 32'd1);
        check("stream_latency_wdata", regfile_wdata_wb_o, 32'hA5A5_A5A5);
        check("stream_ready_1", {31'd0, ex_ready_o}, 32'd1);
        drive(1'b1, 6'd6, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0104, 1'b1);
        tick();
        check("stream_ready_2", {31'd0, ex_ready_o}, 32'd1);
        check("stream_second_waddr", {26'd0, regfile_waddr_wb_o}, 32'd6);
        idle_in();
        tick();
        check_idle("stream_drained");

        // Stall: three entries with wb_ready low
        wb_ready_i = 1'b0;
        drive(1'b1, 6'd7, 32'hC0DE_0007, 1'b0, 1'b0, 32'h0000_0200, 1'b1);
        tick();
        check("stall_ready_after_1st", {31'd0, ex_ready_o}, 32'd1);
        drive(1'b1, 6'd8, 32'hDEAD_0008, 1'b1, 1'b0, 32'h0000_0204, 1'b1);
        tick();
        check("stall_ready_after_2nd", {31'd0, ex_ready_o}, 32'd0);
        drive(1'b1, 6'd9, 32'hEEEE_0009, 1'b0, 1'b0, 32'h0000_0208, 1'b0);
        tick();
        check("stall_ready_held", {31'd0, ex_ready_o}, 32'd0);
        check("stall_head_waddr", {26'd0, regfile_waddr_wb_o}, 32'd7);
        idle_in();
        wb_ready_i = 1'b1;
        tick();
        check("resume_ready", {31'd0, ex_ready_o}, 32'd1);
        check("resume_head_waddr", {26'd0, regfile_waddr_wb_o}, 32'd8);
        tick();
        check_idle("stall_drained");

        // Misaligned first half never writes, then a normal load event
        drive(1'b1, 6'd10, 32'h1234_5678, 1'b1, 1'b1, 32'h0000_0300, 1'b1);
        tick();
        check("misaligned_valid", {31'd0, wb_valid_o}, 32'd1);
        check("misaligned_we_wb", {31'd0, regfile_we_wb_o}, 32'd0);
        drive(1'b1, 6'd11, 32'h0000_0055, 1'b1, 1'b0, 32'h0000_0304, 1'b1);
        tick();
        check("load_event_wb", {31'd0, data_load_event_wb_o}, 32'd1);
        idle_in();
        tick();

        // Flush in FULL with a simultaneous ex_valid
        wb_ready_i = 1'b0;
        drive(1'b1, 6'd12, 32'hF0F0_F0F0, 1'b0, 1'b0, 32'h0000_0400, 1'b0);
        tick();
        drive(1'b1, 6'd13, 32'h0F0F_0F0F, 1'b0, 1'b0, 32'h0000_0404, 1'b0);
        tick();
        check("flush_pre_full", {31'd0, ex_ready_o}, 32'd0);
        drive(1'b1, 6'd14, 32'h1414_1414, 1'b0, 1'b0, 32'h0000_0408, 1'b0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        idle_in();
        check_idle("flush_full");
        wb_ready_i = 1'b1;
        tick();
        check("flush_full_stays_empty", {31'd0, wb_valid_o}, 32'd0);

        // Flush in ONE drops a same-cycle accept
        wb_ready_i = 1'b0;
        drive(1'b1, 6'd15, 32'h0000_0F0F, 1'b0, 1'b0, 32'h0000_0500, 1'b0);
        tick();
        drive(1'b1, 6'd16, 32'h0000_1616, 1'b0, 1'b0, 32'h0000_0504, 1'b0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        idle_in();
        check_idle("flush_one");
        wb_ready_i = 1'b1;
        tick();
        check("flush_one_stays_empty", {31'd0, wb_valid_o}, 32'd0);

        // Post-flush entry still flows
        drive(1'b1, 6'd17, 32'h1717_1717, 1'b0, 1'b0, 32'h0000_0600, 1'b1);
        tick();
        idle_in();
        tick();
        check_idle("post_flush");

`ifdef EX_WB_PARITY_EN
        // Corrupt head wdata bit 0: one error pulse, corrupted data still delivered
        wb_ready_i = 1'b0;
        drive(1'b1, 6'd18, 32'h0000_000F, 1'b0, 1'b0, 32'h0000_0700, 1'b0);
        tick();
        idle_in();
        begin
            exp_t e;
            e.we = 1'b1; e.waddr = 6'd18; e.wdata = 32'h0000_000E; e.le = 1'b0; e.pc = 32'h0000_0700;
            sb.push_back(e);
        end
        check("parity_clean_before", {31'd0, parity_err_o}, 32'd0);
        force dut.head_q.wdata = 32'h0000_000E;
        wb_ready_i = 1'b1;
        tick();
        release dut.head_q.wdata;
        check("parity_err_pulse", {31'd0, parity_err_o}, 32'd1);
        tick();
        check("parity_err_single", {31'd0, parity_err_o}, 32'd0);
`endif

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
